// File: rtl/ssd_pkg.sv
// Shared constants and helpers for the seven-segment scan driver.
package ssd_pkg;

    localparam int unsigned SSD_DIGIT_W = 4;

    // Wide enough for the largest supported digit count; users slice to N_DIGITS.
    localparam logic [7:0] SSD_ANODE_OFF = 8'hFF;

    // Bits needed to hold values 0..value-1, never less than one.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned width;
        width = 1;
        for (int unsigned i = 1; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                width = i + 1;
            end
        end
        return width;
    endfunction

endpackage

// File: rtl/ssd_refresh_tick.sv
// Free-running refresh prescaler: counts 0..REFRESH_DIV-1 while enabled, holds otherwise.
module ssd_refresh_tick
    import ssd_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 50000,
    parameter int unsigned CNT_W       = clog2(REFRESH_DIV)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic             tick_c,
    output logic [CNT_W-1:0] count
);

    logic last_c;

    assign last_c = (count == CNT_W'(REFRESH_DIV - 1));
    assign tick_c = en && last_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (en) begin
            count <= last_c ? '0 : count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/ssd_scan_mux.sv
// Time-multiplexed common-anode seven-segment scan driver.
// Optional anti-ghosting dead time at each slot start: define SSD_DEADTIME_EN.
module ssd_scan_mux
    import ssd_pkg::*;
#(
    parameter int unsigned N_DIGITS    = 4,
    parameter int unsigned REFRESH_DIV = 50000,
    parameter int unsigned DEAD_CYCLES = 2
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            en,
    input  logic [SSD_DIGIT_W*N_DIGITS-1:0] digits,
    input  logic [N_DIGITS-1:0]             dp_in,
    input  logic [N_DIGITS-1:0]             blank,
    output logic [N_DIGITS-1:0]             scan_ctl,
    output logic [SSD_DIGIT_W-1:0]          ssd_in,
    output logic                            dp_out,
    output logic                            frame_done
);

    localparam int unsigned IDX_W = clog2(N_DIGITS);
    localparam int unsigned CNT_W = clog2(REFRESH_DIV);

    logic                   tick_c;
    logic [CNT_W-1:0]       count;
    logic [IDX_W-1:0]       idx;
    logic                   last_idx_c;
    logic                   dead_c;
    logic [SSD_DIGIT_W-1:0] sel_digit_c;
    logic                   sel_dp_c;
    logic                   sel_blank_c;
    logic [N_DIGITS-1:0]    onecold_c;
    logic [N_DIGITS-1:0]    scan_nxt_c;

    ssd_refresh_tick #(
        .REFRESH_DIV (REFRESH_DIV),
        .CNT_W       (CNT_W)
    ) u_refresh_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .tick_c (tick_c),
        .count  (count)
    );

`ifdef SSD_DEADTIME_EN
    assign dead_c = (count < CNT_W'(DEAD_CYCLES));
`else
    logic unused_count;
    assign unused_count = ^count;
    assign dead_c       = 1'b0;
`endif

    assign last_idx_c = (idx == IDX_W'(N_DIGITS - 1));

    // Select the current digit; digit 0 drives the MSB anode enable.
    always_comb begin
        sel_digit_c = '0;
        sel_dp_c    = 1'b0;
        sel_blank_c = 1'b0;
        onecold_c   = SSD_ANODE_OFF[N_DIGITS-1:0];
        for (int unsigned k = 0; k < N_DIGITS; k++) begin
            if (idx == IDX_W'(k)) begin
                sel_digit_c                = digits[k*SSD_DIGIT_W +: SSD_DIGIT_W];
                sel_dp_c                   = dp_in[k];
                sel_blank_c                = blank[k];
                onecold_c[N_DIGITS-1-k]    = 1'b0;
            end
        end
    end

    always_comb begin
        scan_nxt_c = SSD_ANODE_OFF[N_DIGITS-1:0];
        if (en && !sel_blank_c && !dead_c) begin
            scan_nxt_c = onecold_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx        <= '0;
            scan_ctl   <= SSD_ANODE_OFF[N_DIGITS-1:0];
            ssd_in     <= '0;
            dp_out     <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            if (tick_c) begin
                idx <= last_idx_c ? '0 : idx + IDX_W'(1);
            end
            scan_ctl   <= scan_nxt_c;
            ssd_in     <= sel_digit_c;
            dp_out     <= sel_dp_c;
            frame_done <= tick_c && last_idx_c;
        end
    end

endmodule

// File: tb/tb_ssd_scan_mux.sv
// Randomized self-checking bench for ssd_scan_mux (N_DIGITS=4, REFRESH_DIV=4, DEAD_CYCLES=1).
module tb_ssd_scan_mux;

    localparam int N    = 4;
    localparam int DIV  = 4;
    localparam int DEAD = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [15:0] digits = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  blank = '0;
    logic [3:0]  scan_ctl;
    logic [3:0]  ssd_in;
    logic        dp_out;
    logic        frame_done;

    int checks = 0;
    int errors = 0;

    // Reference model: slot position and digit, advanced once per clock.
    int          m_cnt = 0;
    int          m_idx = 0;
    logic [3:0]  exp_scan;
    logic [3:0]  exp_ssd;
    logic        exp_dp;
    logic        exp_fd;
    logic        exp_en;

    ssd_scan_mux #(
        .N_DIGITS    (N),
        .REFRESH_DIV (DIV),
        .DEAD_CYCLES (DEAD)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .digits     (digits),
        .dp_in      (dp_in),
        .blank      (blank),
        .scan_ctl   (scan_ctl),
        .ssd_in     (ssd_in),
        .dp_out     (dp_out),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] onecold(input int i);
        logic [3:0] v;
        v = 4'hF;
        v[N-1-i] = 1'b0;
        return v;
    endfunction

    // Predict what the next edge must produce, advance the model, then clock.
    task automatic step();
        logic dead;
`ifdef SSD_DEADTIME_EN
        dead = (m_cnt < DEAD);
`else
        dead = 1'b0;
`endif
        exp_en   = en;
        exp_scan = (en && !blank[m_idx] && !dead) ? onecold(m_idx) : 4'hF;
        exp_ssd  = digits[4*m_idx +: 4];
        exp_dp   = dp_in[m_idx];
        exp_fd   = en && (m_cnt == DIV-1) && (m_idx == N-1);
        if (en) begin
            if (m_cnt == DIV-1) begin
                m_cnt = 0;
                m_idx = (m_idx + 1) % N;
            end else begin
                m_cnt++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en    = 1'b1;
        digits = 16'hFFFF;
        dp_in = 4'hF;
        #12;
        checks++;
        if (scan_ctl !== 4'hF) begin
            errors++; $display("FAIL reset_scan got %b exp 1111", scan_ctl);
        end
        checks++;
        if (ssd_in !== 4'h0) begin
            errors++; $display("FAIL reset_ssd got %h exp 0", ssd_in);
        end
        checks++;
        if (dp_out !== 1'b0 || frame_done !== 1'b0) begin
            errors++; $display("FAIL reset_dp_fd got %b/%b exp 0/0", dp_out, frame_done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        m_cnt = 0;
        m_idx = 0;
    endtask

    task automatic test_directed_scan();
        logic [3:0] pat [4];
        logic [3:0] want;
        pat[0] = 4'b0111; pat[1] = 4'b1011; pat[2] = 4'b1101; pat[3] = 4'b1110;
        digits = 16'h4321;
        dp_in  = 4'b0000;
        blank  = 4'b0000;
        en     = 1'b1;
        for (int c = 0; c < 20; c++) begin
            step();
            want = pat[(c / 4) % 4];
`ifdef SSD_DEADTIME_EN
            if (c % 4 == 0) want = 4'hF;
`endif
            checks++;
            if (scan_ctl !== want || ssd_in !== 4'((c / 4) % 4 + 1)) begin
                errors++;
                $display("FAIL directed_scan c=%0d got %b/%h exp %b/%h", c, scan_ctl, ssd_in, want, 4'((c / 4) % 4 + 1));
            end
            checks++;
            if (frame_done !== (c == 15)) begin
                errors++; $display("FAIL directed_frame c=%0d got %b exp %b", c, frame_done, (c == 15));
            end
        end
    endtask

    task automatic test_frame_done();
        int got_pulses;
        int exp_pulses;
        got_pulses = 0;
        exp_pulses = 0;
        digits = 16'($urandom);
        dp_in  = 4'($urandom);
        for (int c = 0; c < 48; c++) begin
            step();
            if (frame_done === 1'b1) got_pulses++;
            if (exp_fd) exp_pulses++;
            checks++;
            if (scan_ctl !== exp_scan || frame_done !== exp_fd || ssd_in !== exp_ssd || dp_out !== exp_dp) begin
                errors++;
                $display("FAIL frame_cycle c=%0d got %b/%b/%h/%b exp %b/%b/%h/%b", c, scan_ctl, frame_done,
                         ssd_in, dp_out, exp_scan, exp_fd, exp_ssd, exp_dp);
            end
        end
        checks++;
        if (got_pulses != exp_pulses || exp_pulses != 3) begin
            errors++; $display("FAIL frame_count got %0d exp %0d (3)", got_pulses, exp_pulses);
        end
    endtask

    task automatic test_blank();
        blank = 4'b0100;
        for (int c = 0; c < 64; c++) begin
            if (c >= 32) blank = 4'($urandom);
            digits = 16'($urandom);
            dp_in  = 4'($urandom);
            step();
            checks++;
            if (scan_ctl !== exp_scan || frame_done !== exp_fd || ssd_in !== exp_ssd || dp_out !== exp_dp) begin
                errors++;
                $display("FAIL blank c=%0d blank=%b got %b/%b/%h/%b exp %b/%b/%h/%b", c, blank, scan_ctl,
                         frame_done, ssd_in, dp_out, exp_scan, exp_fd, exp_ssd, exp_dp);
            end
        end
        blank = 4'b0000;
    endtask

    task automatic test_enable();
        int guard;
        guard = 0;
        while (!(m_idx == 1 && m_cnt == 1) && guard < 40) begin
            step();
            guard++;
        end
        checks++;
        if (guard >= 40) begin
            errors++; $display("FAIL enable_align got idx=%0d cnt=%0d exp idx=1 cnt=1", m_idx, m_cnt);
        end
        en = 1'b0;
        for (int c = 0; c < 10; c++) begin
            step();
            checks++;
            if (scan_ctl !== 4'hF || frame_done !== 1'b0) begin
                errors++; $display("FAIL enable_hold c=%0d got %b/%b exp 1111/0", c, scan_ctl, frame_done);
            end
        end
        en = 1'b1;
        // Digit 1 resumes for its remaining three cycles, then digit 2.
        for (int c = 0; c < 4; c++) begin
            step();
            checks++;
            if (scan_ctl !== exp_scan || ssd_in !== exp_ssd || (c < 3 && exp_scan !== 4'hF && scan_ctl !== 4'b1011)) begin
                errors++; $display("FAIL enable_resume c=%0d got %b/%h exp %b/%h", c, scan_ctl, ssd_in, exp_scan, exp_ssd);
            end
        end
        checks++;
        if (scan_ctl !== 4'b1101 && scan_ctl !== 4'hF) begin
            errors++; $display("FAIL enable_next got %b exp 1101", scan_ctl);
        end
        for (int c = 0; c < 80; c++) begin
            en = ($urandom_range(0, 3) != 0);
            digits = 16'($urandom);
            step();
            checks++;
            if (scan_ctl !== exp_scan || frame_done !== exp_fd ||
                (exp_en && (ssd_in !== exp_ssd || dp_out !== exp_dp))) begin
                errors++;
                $display("FAIL enable_rand c=%0d en=%b got %b/%b/%h exp %b/%b/%h", c, exp_en, scan_ctl,
                         frame_done, ssd_in, exp_scan, exp_fd, exp_ssd);
            end
        end
        en = 1'b1;
    endtask

    task automatic test_reset_mid();
        int guard;
        logic [3:0] want;
        guard = 0;
        while (!(m_idx == 2 && m_cnt == 2) && guard < 40) begin
            step();
            guard++;
        end
        checks++;
        if (guard >= 40) begin
            errors++; $display("FAIL rstmid_align got idx=%0d cnt=%0d exp idx=2 cnt=2", m_idx, m_cnt);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (scan_ctl !== 4'hF || ssd_in !== 4'h0 || dp_out !== 1'b0 || frame_done !== 1'b0) begin
            errors++; $display("FAIL rstmid_async got %b/%h/%b/%b exp 1111/0/0/0", scan_ctl, ssd_in, dp_out, frame_done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        m_cnt = 0;
        m_idx = 0;
        digits = 16'($urandom);
        for (int c = 0; c < 8; c++) begin
            step();
            want = (c < 4) ? 4'b0111 : 4'b1011;
`ifdef SSD_DEADTIME_EN
            if (c % 4 == 0) want = 4'hF;
`endif
            checks++;
            if (scan_ctl !== want || scan_ctl !== exp_scan || ssd_in !== exp_ssd) begin
                errors++; $display("FAIL rstmid_restart c=%0d got %b/%h exp %b/%h", c, scan_ctl, ssd_in, want, exp_ssd);
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            en     = ($urandom_range(0, 9) != 0);
            digits = 16'($urandom);
            dp_in  = 4'($urandom);
            blank  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            step();
            checks++;
            if (scan_ctl !== exp_scan || frame_done !== exp_fd ||
                (exp_en && (ssd_in !== exp_ssd || dp_out !== exp_dp))) begin
                errors++;
                $display("FAIL random c=%0d got %b/%b/%h/%b exp %b/%b/%h/%b", c, scan_ctl, frame_done,
                         ssd_in, dp_out, exp_scan, exp_fd, exp_ssd, exp_dp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed_scan();
        test_frame_done();
        test_blank();
        test_enable();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
